// File: rtl/sprite_loader.sv
// Framed byte-stream loader: unpacks two 4-bit pixels per payload byte and issues
// sequential nibble writes into the sprite memory selected by the frame header.
module sprite_loader #(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned DEPTH       = 1536,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned SEL_W       = 4,
  parameter logic [7:0]  SYNC        = 8'hA5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        wr_data,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_en,
  output logic [SEL_W-1:0]  wr_sel,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  // Address of the high nibble of the final pixel pair.
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(DEPTH - 2);

  state_t            state;
  state_t            state_nxt;
  logic              xfer;
  logic              idx_ok;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        chk;
  logic [3:0]        lo_nib;

  assign xfer   = in_valid && in_ready;
  assign idx_ok = 32'(in_data) < NUM_SPRITES;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (xfer && (in_data == SYNC)) state_nxt = S_SEL;
      S_SEL:     if (xfer) state_nxt = idx_ok ? S_DATA_HI : S_IDLE;
      S_DATA_HI: if (xfer) state_nxt = S_DATA_LO;
      S_DATA_LO: state_nxt = (addr == LAST_PAIR) ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (xfer) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; the low-nibble cycle is the only one that refuses a byte
  always_comb begin
    in_ready = 1'b1;
    busy     = 1'b1;
    if (state == S_DATA_LO) in_ready = 1'b0;
    if (state == S_IDLE)    busy     = 1'b0;
  end

  // Registered write port, checksum accumulator and frame status
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_data    <= 4'd0;
      wr_address <= '0;
      wr_en      <= 1'b0;
      wr_sel     <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      addr       <= '0;
      chk        <= 8'd0;
      lo_nib     <= 4'd0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (xfer && (in_data == SYNC)) error <= 1'b0;
        end
        S_SEL: begin
          if (xfer) begin
            if (idx_ok) begin
              wr_sel <= SEL_W'(in_data);
              addr   <= '0;
              chk    <= 8'd0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            wr_en      <= 1'b1;
            wr_data    <= in_data[7:4];
            wr_address <= addr;
            lo_nib     <= in_data[3:0];
            chk        <= chk ^ in_data;
          end
        end
        S_DATA_LO: begin
          wr_en      <= 1'b1;
          wr_data    <= lo_nib;
          wr_address <= addr + ADDR_W'(1);
          addr       <= addr + ADDR_W'(2);
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_data == chk) done  <= 1'b1;
            else                error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader: frame-level write scoreboard plus hand-computed spot checks.
module tb_sprite_loader;

  localparam int unsigned NS    = 16;
  localparam int unsigned DEPTH = 1536;
  localparam int unsigned AW    = 11;
  localparam int unsigned SW    = 4;
  localparam int unsigned NB    = DEPTH / 2;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [3:0]    data;
  } wr_t;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    wr_data;
  logic [AW-1:0] wr_address;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic          busy;
  logic          done;
  logic          error;

  sprite_loader dut (
    .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_data(wr_data), .wr_address(wr_address), .wr_en(wr_en), .wr_sel(wr_sel),
    .busy(busy), .done(done), .error(error)
  );

  always #5 Clk = ~Clk;

  int        vectors = 0;
  int        miscompares = 0;
  int        wr_cnt = 0;
  int        done_cnt = 0;
  bit        jitter = 1'b0;
  wr_t       exp_q[$];
  wr_t       exp_w;
  logic [3:0] img [2**AW];
  logic [7:0] pay [NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'd0;
    for (int k = 0; k < NB; k++) x ^= pay[k];
    return x;
  endfunction

  // Every write must be the next one the frame model predicts; in_ready drops only while the
  // low nibble of a pair is being written (the cycle showing the even-address write).
  always @(negedge Clk) begin
    if (!Reset) begin
      check("in_ready_rule", 32'(in_ready), 32'(!(wr_en && !wr_address[0])));
      check("done_error_exclusive", 32'(done && error), 32'd0);
      if (done) done_cnt++;
      if (wr_en) begin
        wr_cnt++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("write", 32'({wr_sel, wr_address, wr_data}), 32'(exp_w));
        img[wr_address] = wr_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    forever begin
      @(negedge Clk);
      if (jitter && ($urandom_range(1) == 0)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) begin
          @(posedge Clk);
          #1 in_valid = 1'b0;
          return;
        end
      end
      tries++;
      if (tries > 60) begin
        check("accept_timeout", 32'(tries), 32'd0);
        return;
      end
    end
  endtask

  task automatic push_writes(input logic [7:0] idx, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      exp_q.push_back('{sel: SW'(idx), addr: AW'(2 * k),     data: pay[k][7:4]});
      exp_q.push_back('{sel: SW'(idx), addr: AW'(2 * k + 1), data: pay[k][3:0]});
    end
  endtask

  task automatic send_frame(input logic [7:0] idx, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(idx);
    if (32'(idx) < NS) begin
      push_writes(idx, NB);
      for (int k = 0; k < NB; k++) send_byte(pay[k]);
      send_byte(chk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      in_valid = 1'b0;
    end
  endtask

  int wr0, dn0;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    idle(2);

    // 1: reset in idle, outputs quiet and stable
    Reset = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      check("reset_outputs", 32'({wr_data, wr_address, wr_en, wr_sel, done, error, busy, in_ready}), 32'd1);
    end
    Reset = 1'b0;
    idle(2);

    // 2: junk then good frame to sprite 3, payload byte k = k[7:0]
    for (int k = 0; k < NB; k++) pay[k] = 8'(k);
    check("model_xor_pin", 32'(xor_all()), 32'h00);
    wr0 = wr_cnt; dn0 = done_cnt;
    send_byte(8'h00);
    send_byte(8'h17);
    check("junk_ignored_busy", 32'(busy), 32'd0);
    send_frame(8'h03, 8'h00);
    idle(3);
    check("t2_writes", 32'(wr_cnt - wr0), 32'd1536);
    check("t2_done", 32'(done_cnt - dn0), 32'd1);
    check("t2_error", 32'(error), 32'd0);
    check("t2_sel", 32'(wr_sel), 32'd3);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    check("t2_img_6e", 32'(img[11'h06E]), 32'h3);
    check("t2_img_6f", 32'(img[11'h06F]), 32'h7);
    check("t2_img_200", 32'(img[11'h200]), 32'h0);
    check("t2_img_5fe", 32'(img[11'h5FE]), 32'hF);
    check("t2_img_5ff", 32'(img[11'h5FF]), 32'hF);

    // 3: same frame, wrong checksum; error clears on next SYNC
    wr0 = wr_cnt; dn0 = done_cnt;
    send_frame(8'h03, 8'hFF);
    idle(3);
    check("t3_writes", 32'(wr_cnt - wr0), 32'd1536);
    check("t3_done", 32'(done_cnt - dn0), 32'd0);
    check("t3_error", 32'(error), 32'd1);
    idle(2);
    check("t3_error_sticky", 32'(error), 32'd1);
    send_byte(8'hA5);
    @(negedge Clk);
    check("t3_error_cleared", 32'(error), 32'd0);
    check("t3_busy_in_sel", 32'(busy), 32'd1);
    send_byte(8'h10);
    idle(2);
    check("t3_bad_index", 32'(error), 32'd1);

    // 4: out-of-range index, then a good frame to sprite 0
    wr0 = wr_cnt;
    send_frame(8'h10, 8'h00);
    idle(3);
    check("t4_no_writes", 32'(wr_cnt - wr0), 32'd0);
    check("t4_error", 32'(error), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    for (int k = 0; k < NB; k++) pay[k] = 8'(k * 7 + 3);
    wr0 = wr_cnt; dn0 = done_cnt;
    send_frame(8'h00, xor_all());
    idle(3);
    check("t4_writes", 32'(wr_cnt - wr0), 32'd1536);
    check("t4_done", 32'(done_cnt - dn0), 32'd1);
    check("t4_error_clear", 32'(error), 32'd0);

    // 5: random in_valid, payload containing SYNC bytes
    for (int k = 0; k < NB; k++) pay[k] = (k % 16 == 5) ? 8'hA5 : 8'($urandom);
    jitter = 1'b1;
    wr0 = wr_cnt; dn0 = done_cnt;
    send_frame(8'h07, xor_all());
    jitter = 1'b0;
    idle(3);
    check("t5_writes", 32'(wr_cnt - wr0), 32'd1536);
    check("t5_done", 32'(done_cnt - dn0), 32'd1);
    check("t5_queue", 32'(exp_q.size()), 32'd0);
    check("t5_img_a5_hi", 32'(img[11'd10]), 32'hA);
    check("t5_img_a5_lo", 32'(img[11'd11]), 32'h5);

    // 6: reset after 100 payload bytes, then a clean frame to sprite 5
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
    send_byte(8'hA5);
    send_byte(8'h02);
    push_writes(8'h02, 99);
    for (int k = 0; k < 100; k++) send_byte(pay[k]);
    Reset = 1'b1;
    #1;
    check("t6_wr_en_reset", 32'(wr_en), 32'd0);
    check("t6_busy_reset", 32'(busy), 32'd0);
    check("t6_queue", 32'(exp_q.size()), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    idle(2);
    for (int k = 0; k < NB; k++) pay[k] = 8'(k ^ 8'h5A);
    wr0 = wr_cnt; dn0 = done_cnt;
    send_frame(8'h05, xor_all());
    idle(3);
    check("t6_writes", 32'(wr_cnt - wr0), 32'd1536);
    check("t6_done", 32'(done_cnt - dn0), 32'd1);
    check("t6_sel", 32'(wr_sel), 32'd5);
    check("t6_error", 32'(error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
